// File: rtl/ber_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ber_seq_ctrl
// Brief    : Per-lane sequencer for the PRBS9 BER checker. Sweeps the
//            reference delay to find alignment. Runs a bounded error-count
//            window with loss-of-lock detection. Reports counts and status.
// Revision : 1.0 - initial release
// ============================================================================
module ber_seq_ctrl #(
  parameter int PRBS_LEN    = 511,
  parameter int WIN_LEN     = 511,
  parameter int SETTLE_SYMS = 8,
  parameter int COUNT_LEN   = 261121,
  parameter int LOL_THR     = 128,
  parameter int CNT_W       = 40
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en_rate1,
  input  logic             i_err,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [8:0]       o_delay,
  output logic [2:0]       o_state,
  output logic             o_locked,
  output logic             o_done,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_ber_ok
);

  // Window error count never exceeds WIN_LEN, so this width cannot overflow.
  localparam int c_WIN_W = $clog2(WIN_LEN + 1);
  localparam int c_SET_W = (SETTLE_SYMS > 0) ? $clog2(SETTLE_SYMS + 1) : 1;

  localparam logic [c_WIN_W-1:0] c_WIN_LEN    = c_WIN_W'(WIN_LEN);
  localparam logic [c_SET_W-1:0] c_SETTLE     = c_SET_W'(SETTLE_SYMS);
  localparam logic [8:0]         c_LAST_DELAY = 9'(PRBS_LEN - 1);
  localparam logic [CNT_W-1:0]   c_COUNT_LEN  = CNT_W'(COUNT_LEN);
  localparam bit                 c_COUNT_EN   = (COUNT_LEN != 0);
  localparam logic [31:0]        c_LOL_THR    = 32'(LOL_THR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SEARCH = 3'd2,
    S_COUNT  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state,      w_state_nxt;
  state_t               r_target,     w_target_nxt;
  logic [8:0]           r_delay,      w_delay_nxt;
  logic [8:0]           r_best_delay, w_best_delay_nxt;
  logic [c_WIN_W-1:0]   r_best_err,   w_best_err_nxt;
  logic [c_WIN_W-1:0]   r_win_cnt,    w_win_cnt_nxt;
  logic [c_WIN_W-1:0]   r_win_err,    w_win_err_nxt;
  logic [c_SET_W-1:0]   r_settle_cnt, w_settle_cnt_nxt;
  logic [CNT_W-1:0]     r_bit_cnt,    w_bit_cnt_nxt;
  logic [CNT_W-1:0]     r_err_cnt,    w_err_cnt_nxt;
  logic                 r_locked,     w_locked_nxt;
  logic                 r_done,       w_done_nxt;
  logic                 r_ber_ok,     w_ber_ok_nxt;

  logic [c_WIN_W-1:0]   w_win_cnt_inc;
  logic [c_WIN_W-1:0]   w_win_err_acc;
  logic                 w_win_end;
  logic [c_SET_W-1:0]   w_settle_inc;
  logic                 w_settle_end;
  logic [CNT_W-1:0]     w_bit_inc;
  logic [CNT_W-1:0]     w_err_inc;
  logic                 w_new_best;
  logic                 w_lol;

  // Shared arithmetic for the window, settle and saturating event counters.
  always_comb begin
    w_win_cnt_inc = r_win_cnt + c_WIN_W'(1);
    w_win_err_acc = r_win_err + c_WIN_W'(i_err);
    w_win_end     = (w_win_cnt_inc == c_WIN_LEN);
    w_settle_inc  = r_settle_cnt + c_SET_W'(1);
    w_settle_end  = (w_settle_inc >= c_SETTLE);
    w_bit_inc     = (&r_bit_cnt) ? r_bit_cnt : r_bit_cnt + CNT_W'(1);
    w_err_inc     = (i_err && !(&r_err_cnt)) ? r_err_cnt + CNT_W'(1) : r_err_cnt;
    // Strict compare: on a tie the earlier (lower) delay is kept.
    w_new_best    = (w_win_err_acc < r_best_err);
    w_lol         = (32'(w_win_err_acc) > c_LOL_THR);
  end

  // Next-state and next-value logic for the sequencer.
  always_comb begin
    w_state_nxt      = r_state;
    w_target_nxt     = r_target;
    w_delay_nxt      = r_delay;
    w_best_delay_nxt = r_best_delay;
    w_best_err_nxt   = r_best_err;
    w_win_cnt_nxt    = r_win_cnt;
    w_win_err_nxt    = r_win_err;
    w_settle_cnt_nxt = r_settle_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_err_cnt_nxt    = r_err_cnt;
    w_locked_nxt     = r_locked;
    w_done_nxt       = 1'b0;

    if (i_stop) begin
      // Abort: counters are left intact so they can still be read out.
      w_state_nxt      = S_IDLE;
      w_locked_nxt     = 1'b0;
      w_settle_cnt_nxt = '0;
      w_win_cnt_nxt    = '0;
      w_win_err_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            w_state_nxt      = S_SETTLE;
            w_target_nxt     = S_SEARCH;
            w_delay_nxt      = '0;
            w_best_delay_nxt = '0;
            w_best_err_nxt   = '1;
            w_bit_cnt_nxt    = '0;
            w_err_cnt_nxt    = '0;
            w_locked_nxt     = 1'b0;
            w_settle_cnt_nxt = '0;
            w_win_cnt_nxt    = '0;
            w_win_err_nxt    = '0;
          end
        end

        S_SETTLE: begin
          // Errors are ignored here while the compare pipeline flushes.
          if (i_en_rate1) begin
            w_settle_cnt_nxt = w_settle_inc;
            if (w_settle_end) begin
              w_state_nxt      = r_target;
              w_settle_cnt_nxt = '0;
              w_win_cnt_nxt    = '0;
              w_win_err_nxt    = '0;
              if (r_target == S_COUNT) begin
                w_locked_nxt = 1'b1;
              end
            end
          end
        end

        S_SEARCH: begin
          if (i_en_rate1) begin
            w_win_cnt_nxt = w_win_cnt_inc;
            w_win_err_nxt = w_win_err_acc;
            if (w_win_end) begin
              w_win_cnt_nxt    = '0;
              w_win_err_nxt    = '0;
              w_settle_cnt_nxt = '0;
              w_state_nxt      = S_SETTLE;
              if (w_new_best) begin
                w_best_err_nxt   = w_win_err_acc;
                w_best_delay_nxt = r_delay;
              end
              if ((w_win_err_acc == '0) || (r_delay == c_LAST_DELAY)) begin
                // Park on the best delay found, including this window's.
                w_delay_nxt  = w_new_best ? r_delay : r_best_delay;
                w_target_nxt = S_COUNT;
              end else begin
                w_delay_nxt  = r_delay + 9'd1;
                w_target_nxt = S_SEARCH;
              end
            end
          end
        end

        S_COUNT: begin
          if (i_en_rate1) begin
            w_bit_cnt_nxt = w_bit_inc;
            w_err_cnt_nxt = w_err_inc;
            w_win_cnt_nxt = w_win_cnt_inc;
            w_win_err_nxt = w_win_err_acc;
            if (w_win_end) begin
              w_win_cnt_nxt = '0;
              w_win_err_nxt = '0;
            end
            // Loss of lock outranks completion in the same cycle.
            if (w_win_end && w_lol) begin
              w_locked_nxt     = 1'b0;
              w_bit_cnt_nxt    = '0;
              w_err_cnt_nxt    = '0;
              w_delay_nxt      = '0;
              w_best_delay_nxt = '0;
              w_best_err_nxt   = '1;
              w_settle_cnt_nxt = '0;
              w_state_nxt      = S_SETTLE;
              w_target_nxt     = S_SEARCH;
            end else if (c_COUNT_EN && (w_bit_inc == c_COUNT_LEN)) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_ber_ok_nxt = (w_state_nxt == S_DONE) && (w_err_cnt_nxt == '0);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_target     <= S_SEARCH;
      r_delay      <= '0;
      r_best_delay <= '0;
      r_best_err   <= '1;
      r_win_cnt    <= '0;
      r_win_err    <= '0;
      r_settle_cnt <= '0;
      r_bit_cnt    <= '0;
      r_err_cnt    <= '0;
      r_locked     <= 1'b0;
      r_done       <= 1'b0;
      r_ber_ok     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_target     <= w_target_nxt;
      r_delay      <= w_delay_nxt;
      r_best_delay <= w_best_delay_nxt;
      r_best_err   <= w_best_err_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_win_err    <= w_win_err_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_locked     <= w_locked_nxt;
      r_done       <= w_done_nxt;
      r_ber_ok     <= w_ber_ok_nxt;
    end
  end

  assign o_delay   = r_delay;
  assign o_state   = r_state;
  assign o_locked  = r_locked;
  assign o_done    = r_done;
  assign o_bit_cnt = r_bit_cnt;
  assign o_err_cnt = r_err_cnt;
  assign o_ber_ok  = r_ber_ok;

endmodule
`default_nettype wire

// File: tb/tb_ber_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ber_seq_ctrl
// Brief    : Directed bench for ber_seq_ctrl: delay sweep, tie-break, lock,
//            loss of lock, stop/start/reset handling and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ber_seq_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_en_rate1, i_err, i_start, i_stop;
  logic [8:0]  o_delay;
  logic [2:0]  o_state;
  logic        o_locked, o_done, o_ber_ok;
  logic [39:0] o_bit_cnt, o_err_cnt;

  logic        i_reset_b, i_start_b, i_stop_b;
  logic [8:0]  o_delay_b;
  logic [2:0]  o_state_b;
  logic        o_locked_b, o_done_b, o_ber_ok_b;
  logic [3:0]  o_bit_cnt_b, o_err_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ber_seq_ctrl #(
    .PRBS_LEN(7), .WIN_LEN(16), .SETTLE_SYMS(2), .COUNT_LEN(100), .LOL_THR(4), .CNT_W(40)
  ) u_dut (
    .clk(clk), .i_reset(i_reset), .i_en_rate1(i_en_rate1), .i_err(i_err),
    .i_start(i_start), .i_stop(i_stop), .o_delay(o_delay), .o_state(o_state),
    .o_locked(o_locked), .o_done(o_done), .o_bit_cnt(o_bit_cnt),
    .o_err_cnt(o_err_cnt), .o_ber_ok(o_ber_ok)
  );

  ber_seq_ctrl #(
    .PRBS_LEN(7), .WIN_LEN(16), .SETTLE_SYMS(2), .COUNT_LEN(0), .LOL_THR(16), .CNT_W(4)
  ) u_dut_sat (
    .clk(clk), .i_reset(i_reset_b), .i_en_rate1(i_en_rate1), .i_err(i_err),
    .i_start(i_start_b), .i_stop(i_stop_b), .o_delay(o_delay_b), .o_state(o_state_b),
    .o_locked(o_locked_b), .o_done(o_done_b), .o_bit_cnt(o_bit_cnt_b),
    .o_err_cnt(o_err_cnt_b), .o_ber_ok(o_ber_ok_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One strobe every 4 cycles; i_err is held high on non-strobe cycles so any
  // sampling without i_en_rate1 shows up as a miscount.
  task automatic sym(input logic e);
    i_en_rate1 = 1'b0; i_err = 1'b1;
    tick(); tick(); tick();
    i_en_rate1 = 1'b1; i_err = e;
    tick();
    i_en_rate1 = 1'b0; i_err = 1'b1;
  endtask

  // n strobes, the first nerr of them errored.
  task automatic syms(input int n, input int nerr);
    for (int k = 0; k < n; k++) sym(k < nerr);
  endtask

  task automatic settle();
    syms(2, 2);
  endtask

  task automatic pulse(input logic st, input logic sp);
    i_start = st; i_stop = sp;
    tick();
    i_start = 1'b0; i_stop = 1'b0;
  endtask

  int errs2 [7] = '{8, 9, 2, 10, 8, 2, 8};

  initial begin
    i_reset = 1'b1; i_reset_b = 1'b1;
    i_en_rate1 = 1'b0; i_err = 1'b0;
    i_start = 1'b0; i_stop = 1'b0; i_start_b = 1'b0; i_stop_b = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    tick();

    // ---- reset state ----
    chk("rst_state", o_state, 0);
    chk("rst_delay", o_delay, 0);
    chk("rst_locked", o_locked, 0);
    chk("rst_done", o_done, 0);
    chk("rst_bit", o_bit_cnt, 0);
    chk("rst_err", o_err_cnt, 0);
    chk("rst_ber_ok", o_ber_ok, 0);

    // ---- sweep 0..3, lock at 3 ----
    pulse(1'b1, 1'b0);
    chk("t1_settle", o_state, 1);
    settle();
    chk("t1_search", o_state, 2);
    chk("t1_d0", o_delay, 0);
    syms(16, 3);
    chk("t1_after_d0_state", o_state, 1);
    chk("t1_after_d0_delay", o_delay, 1);
    settle(); syms(16, 3);
    settle(); syms(16, 3);
    chk("t1_delay3", o_delay, 3);
    settle(); syms(16, 0);
    chk("t1_lock_state", o_state, 1);
    chk("t1_lock_delay", o_delay, 3);
    chk("t1_lock_pre", o_locked, 0);
    settle();
    chk("t1_count", o_state, 3);
    chk("t1_locked", o_locked, 1);
    chk("t1_bit0", o_bit_cnt, 0);
    syms(99, 0);
    chk("t1_bit99", o_bit_cnt, 99);
    chk("t1_not_done", o_done, 0);
    sym(1'b0);
    chk("t1_done_state", o_state, 4);
    chk("t1_done_pulse", o_done, 1);
    chk("t1_bit100", o_bit_cnt, 100);
    chk("t1_err0", o_err_cnt, 0);
    chk("t1_ber_ok", o_ber_ok, 1);
    tick();
    chk("t1_done_drop", o_done, 0);
    chk("t1_hold_bit", o_bit_cnt, 100);
    chk("t1_hold_locked", o_locked, 1);

    // ---- full sweep, tie keeps lower delay ----
    pulse(1'b1, 1'b0);
    chk("t2_clr_bit", o_bit_cnt, 0);
    chk("t2_clr_locked", o_locked, 0);
    chk("t2_clr_delay", o_delay, 0);
    for (int d = 0; d < 7; d++) begin
      settle();
      syms(16, errs2[d]);
    end
    chk("t2_best_delay", o_delay, 2);
    chk("t2_state", o_state, 1);
    settle();
    chk("t2_count", o_state, 3);
    syms(10, 3);
    pulse(1'b1, 1'b0);
    chk("t2_start_ignored", o_state, 3);
    chk("t2_bit10", o_bit_cnt, 10);
    syms(90, 0);
    chk("t2_done", o_done, 1);
    chk("t2_err3", o_err_cnt, 3);
    chk("t2_ber_bad", o_ber_ok, 0);

    // ---- loss of lock ----
    pulse(1'b1, 1'b0);
    settle(); syms(16, 1);
    settle(); syms(16, 0);
    chk("t3_lock_delay", o_delay, 1);
    settle();
    chk("t3_count", o_state, 3);
    syms(15, 5);
    chk("t3_bit15", o_bit_cnt, 15);
    chk("t3_err5", o_err_cnt, 5);
    chk("t3_still_locked", o_locked, 1);
    sym(1'b0);
    chk("t3_lol_state", o_state, 1);
    chk("t3_lol_locked", o_locked, 0);
    chk("t3_lol_bit", o_bit_cnt, 0);
    chk("t3_lol_err", o_err_cnt, 0);
    chk("t3_lol_delay", o_delay, 0);
    settle();
    chk("t3_research", o_state, 2);

    // ---- stop mid-SEARCH at delay 4; start+stop together ----
    for (int d = 0; d < 4; d++) begin
      syms(16, 3);
      settle();
    end
    chk("t4_search", o_state, 2);
    chk("t4_delay4", o_delay, 4);
    syms(3, 1);
    pulse(1'b0, 1'b1);
    chk("t4_stop", o_state, 0);
    pulse(1'b1, 1'b1);
    chk("t4_stop_wins", o_state, 0);

    // ---- reset during COUNT ----
    pulse(1'b1, 1'b0);
    settle(); syms(16, 1);
    settle(); syms(16, 0);
    settle();
    syms(50, 1);
    chk("t5_bit50", o_bit_cnt, 50);
    chk("t5_err1", o_err_cnt, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("t5_state", o_state, 0);
    chk("t5_delay", o_delay, 0);
    chk("t5_locked", o_locked, 0);
    chk("t5_bit", o_bit_cnt, 0);
    chk("t5_err", o_err_cnt, 0);

    // ---- stop in COUNT holds counters ----
    pulse(1'b1, 1'b0);
    settle(); syms(16, 0);
    settle();
    syms(20, 2);
    pulse(1'b0, 1'b1);
    chk("t6_state", o_state, 0);
    chk("t6_locked", o_locked, 0);
    chk("t6_bit", o_bit_cnt, 20);
    chk("t6_err", o_err_cnt, 2);

    // ---- saturation with 4-bit counters, unbounded COUNT ----
    i_reset_b = 1'b0;
    tick();
    i_start_b = 1'b1;
    tick();
    i_start_b = 1'b0;
    settle(); syms(16, 0);
    settle();
    chk("t7_count", o_state_b, 3);
    syms(20, 20);
    chk("t7_bit_sat", o_bit_cnt_b, 15);
    chk("t7_err_sat", o_err_cnt_b, 15);
    chk("t7_still_count", o_state_b, 3);
    chk("t7_locked", o_locked_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
